// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types and helpers for the SR-latch access controller.
package sr_latch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_REFRESH = 2'b00,
        CMD_SET     = 2'b01,
        CMD_RESET   = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_t;

    // Wide enough to hold the longest phase length.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Index of the requester granted most recently; reset favours requester 0.
    logic last_q;

    always_comb begin
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance && (|grant)) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/sr_latch_access_ctrl.sv
// Shares one gated SR latch between two requesters: setup, enable pulse, hold,
// then a one-cycle done, with S/R frozen whenever C is high.
module sr_latch_access_ctrl
    import sr_latch_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] cmd0,
    input  logic [1:0] cmd1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       err,
    output logic       busy,
    output logic       latch_s,
    output logic       latch_r,
    output logic       latch_c,
    output logic [2:0] state_dbg
);

    localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    cmd_t            cmd_q, cmd_d;
    logic            owner_q, owner_d;
    logic            advance;
    logic [1:0]      arb_gnt;

    logic            active_d, busy_d, err_d, s_d, r_d, c_d;
    logic [1:0]      gnt_d, done_d;
    logic [1:0]      gnt_q, done_q;
    logic            err_q, busy_q, s_q, r_q, c_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance),
        .grant   (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        cmd_d   = cmd_q;
        owner_d = owner_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    advance = 1'b1;
                    owner_d = arb_gnt[1] & ~arb_gnt[0];
                    cmd_d   = owner_d ? cmd_t'(cmd1) : cmd_t'(cmd0);
                    state_d = (cmd_d == CMD_ILLEGAL) ? DONE : SETUP;
                end
            end
            SETUP: if (cnt_q == SETUP_LAST) begin
                state_d = PULSE;
                cnt_d   = '0;
            end
            PULSE: if (cnt_q == PULSE_LAST) begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: if (cnt_q == HOLD_LAST) begin
                state_d = DONE;
                cnt_d   = '0;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        active_d = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
        busy_d   = (state_d != IDLE);
        gnt_d    = busy_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
        done_d   = (state_d == DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
        err_d    = (state_d == DONE) && (cmd_d == CMD_ILLEGAL);
        s_d      = active_d && (cmd_d == CMD_SET);
        r_d      = active_d && (cmd_d == CMD_RESET);
        c_d      = (state_d == PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= CMD_REFRESH;
            owner_q <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            s_q     <= s_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign latch_s   = s_q;
    assign latch_r   = r_q;
    assign latch_c   = c_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sr_latch_access_ctrl.sv
// Bench for sr_latch_access_ctrl: directed requests, a done-driven scoreboard
// checking per-sequence latch activity and latency, and per-cycle invariants.
module tb_sr_latch_access_ctrl;
    import sr_latch_ctrl_pkg::*;

    localparam int W = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0  = 1'b0;
    logic       req1  = 1'b0;
    logic [1:0] req;
    logic [1:0] cmd0  = 2'b00;
    logic [1:0] cmd1  = 2'b00;
    logic [1:0] gnt, done;
    logic       err, busy, latch_s, latch_r, latch_c;
    logic [2:0] state_dbg;

    logic       sw_req = 1'b0;
    logic [1:0] sw_cmd = 2'b00;
    logic [1:0] sw_gnt, sw_done;
    logic       sw_err, sw_busy, sw_s, sw_r, sw_c;
    logic [2:0] sw_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    assign req = {req1, req0};

    sr_latch_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd0(cmd0), .cmd1(cmd1),
        .gnt(gnt), .done(done), .err(err), .busy(busy),
        .latch_s(latch_s), .latch_r(latch_r), .latch_c(latch_c),
        .state_dbg(state_dbg)
    );

    sr_latch_access_ctrl #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req({1'b0, sw_req}), .cmd0(sw_cmd), .cmd1(2'b00),
        .gnt(sw_gnt), .done(sw_done), .err(sw_err), .busy(sw_busy),
        .latch_s(sw_s), .latch_r(sw_r), .latch_c(sw_c),
        .state_dbg(sw_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // {done, err, S cycles, R cycles, C cycles, busy cycles up to and including done}
    function automatic logic [W-1:0] mk(input logic [1:0] d, input logic e,
                                         input int s, input int r, input int c, input int l);
        return {d, e, 4'(s), 4'(r), 4'(c), 5'(l)};
    endfunction

    // Monitor: accumulates per-sequence activity, pops on done, checks invariants.
    initial begin
        logic [3:0] s_cnt, r_cnt, c_cnt;
        logic [4:0] lat;
        logic       prev_s, prev_r, prev_c;
        s_cnt = '0; r_cnt = '0; c_cnt = '0; lat = '0;
        prev_s = 1'b0; prev_r = 1'b0; prev_c = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_cnt = '0; r_cnt = '0; c_cnt = '0; lat = '0;
                prev_c = 1'b0;
            end else begin
                check("inv_s_and_r", 32'(latch_s & latch_r), 32'd0);
                check("inv_c_only_in_pulse", 32'(latch_c && (state_dbg != 3'(PULSE))), 32'd0);
                if (latch_c && prev_c)
                    check("inv_sr_stable_while_c", 32'({latch_s, latch_r}), 32'({prev_s, prev_r}));
                check("inv_sweep_s_and_r", 32'(sw_s & sw_r), 32'd0);
                prev_s = latch_s; prev_r = latch_r; prev_c = latch_c;
                if (busy) begin
                    lat   = lat + 5'd1;
                    s_cnt = s_cnt + 4'(latch_s);
                    r_cnt = r_cnt + 4'(latch_r);
                    c_cnt = c_cnt + 4'(latch_c);
                end
                if (done != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=%b with nothing expected", done);
                    end else begin
                        check("scoreboard", 32'({done, err, s_cnt, r_cnt, c_cnt, lat}),
                              32'(exp_q.pop_front()));
                    end
                    s_cnt = '0; r_cnt = '0; c_cnt = '0; lat = '0;
                end else if (!busy) begin
                    s_cnt = '0; r_cnt = '0; c_cnt = '0; lat = '0;
                end
            end
        end
    end

    task automatic wait_done(input int id, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done[id]) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_done%0d: no done within %0d cycles", id, bound);
        end
    endtask

    task automatic run_req(input int id, input logic [1:0] cmd);
        if (id == 0) begin cmd0 = cmd; req0 = 1'b1; end
        else         begin cmd1 = cmd; req1 = 1'b1; end
        wait_done(id, 40);
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] sweep_tbl [1:4];
        sweep_tbl[1] = 5'b00_100;
        sweep_tbl[2] = 5'b00_101;
        sweep_tbl[3] = 5'b00_100;
        sweep_tbl[4] = 5'b01_000;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt",  32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_latch", 32'({latch_s, latch_r, latch_c}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Set via requester 0
        exp_q.push_back(mk(2'b01, 1'b0, 6, 0, 3, 7));
        run_req(0, CMD_SET);
        @(negedge clk);

        // Contention from reset, both held: grants 0, 1, 0 with an idle gap each
        do_reset();
        exp_q.push_back(mk(2'b01, 1'b0, 6, 0, 3, 7));
        exp_q.push_back(mk(2'b10, 1'b0, 0, 6, 3, 7));
        exp_q.push_back(mk(2'b01, 1'b0, 6, 0, 3, 7));
        cmd0 = CMD_SET; cmd1 = CMD_RESET; req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        check("contend_first_gnt", 32'(gnt), 32'b01);
        wait_done(0, 20);
        wait_done(1, 20);
        wait_done(0, 20);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Illegal command from requester 1
        exp_q.push_back(mk(2'b10, 1'b1, 0, 0, 0, 1));
        run_req(1, CMD_ILLEGAL);
        @(negedge clk);
        check("illegal_back_idle", 32'(busy), 32'd0);

        // Refresh with cmd toggling and req dropped after grant
        exp_q.push_back(mk(2'b01, 1'b0, 0, 0, 3, 7));
        cmd0 = CMD_REFRESH; req0 = 1'b1;
        @(negedge clk);
        check("refresh_gnt", 32'(gnt), 32'b01);
        req0 = 1'b0; cmd0 = CMD_SET;
        @(negedge clk);
        cmd0 = CMD_RESET;
        @(negedge clk);
        cmd0 = CMD_ILLEGAL;
        wait_done(0, 20);
        cmd0 = CMD_REFRESH;
        @(negedge clk);

        // Reset command with a later cmd change that must be ignored
        exp_q.push_back(mk(2'b01, 1'b0, 0, 6, 3, 7));
        cmd0 = CMD_RESET; req0 = 1'b1;
        @(negedge clk);
        cmd0 = CMD_SET;
        wait_done(0, 20);
        req0 = 1'b0;
        @(negedge clk);

        // Reset mid-PULSE: outputs drop without a clock edge, no done
        cmd0 = CMD_SET; req0 = 1'b1;
        for (int i = 0; i < 10 && !latch_c; i++) @(negedge clk);
        check("pulse_reached", 32'(latch_c), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_latch", 32'({latch_s, latch_r, latch_c}), 32'd0);
        check("async_rst_gnt",   32'(gnt), 32'd0);
        check("async_rst_busy",  32'(busy), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(2'b01, 1'b0, 6, 0, 3, 7));
        exp_q.push_back(mk(2'b10, 1'b0, 0, 6, 3, 7));
        fork
            run_req(0, CMD_SET);
            run_req(1, CMD_RESET);
        join
        @(negedge clk);

        // Short-phase instance: done at cycle 4
        sw_cmd = CMD_SET; sw_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("sweep_cycle%0d", c), 32'({sw_done, sw_s, sw_r, sw_c}), 32'(sweep_tbl[c]));
        end
        sw_req = 1'b0;
        repeat (3) @(negedge clk);
        check("sweep_idle", 32'(sw_busy), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_latch_access_ctrl.md
Name: sr_latch_access_ctrl

Overview:
- Sequences and shares one level-sensitive SR latch (gated S/R inputs plus enable C) between two requesters.
- Performs round-robin arbitration, then drives S/R with a setup interval, asserts C for a fixed pulse, and holds S/R after C falls, so the latch never sees S/R change while C is high.
- Sits between board-level command sources (debounced switch/key logic) and the latch.

Parameters:
- SETUP_CYC, 2, cycles S/R are stable before C rises (minimum 1)
- PULSE_CYC, 3, cycles C is high (minimum 1)
- HOLD_CYC, 1, cycles S/R stay stable after C falls (minimum 1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  request per requester; held high until that requester's done
- cmd0  in  2  requester 0 command: 00 refresh (C pulse, S=R=0), 01 set, 10 reset, 11 illegal
- cmd1  in  2  requester 1 command, same encoding
- gnt  out  2  one-hot grant, high from SETUP through DONE
- done  out  2  one-cycle completion pulse to the owner
- err  out  1  one-cycle pulse, coincident with done, when the command was 11
- busy  out  1  high in every state except IDLE
- latch_s  out  1  S to latch
- latch_r  out  1  R to latch
- latch_c  out  1  C (enable) to latch

Behaviour:
- Reset (async, immediate):
  - state=IDLE, all outputs 0, cycle counter 0.
  - Round-robin pointer set so requester 0 wins the first tie.
  - Reset mid-sequence drops C, S and R in the same instant; no done is issued.
- All outputs are registered or decoded from registered state only. No combinational path from req/cmd to outputs.
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE.
- IDLE:
  - If any req bit is 1, the arbiter picks an owner; the owner's cmd is captured into cmd_q at that edge.
  - cmd_q=11 -> next state DONE, with err flagged.
  - Otherwise -> next state SETUP.
  - No req -> stay in IDLE.
- Arbitration:
  - Single request wins.
  - Both requesting: the requester not granted last wins. The pointer updates only on grant.
- SETUP: latch_s=(cmd_q==01), latch_r=(cmd_q==10), latch_c=0. Lasts SETUP_CYC cycles, then PULSE.
- PULSE: S/R as in SETUP, latch_c=1. Lasts PULSE_CYC cycles, then HOLD.
- HOLD: S/R held, latch_c=0. Lasts HOLD_CYC cycles, then DONE.
- DONE:
  - S=R=C=0; done[owner]=1; err=1 if cmd_q was 11.
  - Exactly one cycle, then IDLE.
- gnt[owner]:
  - High in SETUP, PULSE, HOLD and DONE.
  - For an illegal command, high in DONE only.
- Latency (defaults): req sampled at edge 0 -> S/R in cycles 1-6, C in cycles 3-5, done in cycle 7.
  - General: done at 1+SETUP_CYC+PULSE_CYC+HOLD_CYC.
  - Illegal command: done/err in cycle 1.
- IDLE lasts at least one cycle between sequences, so back-to-back grants are separated by that idle cycle.
- cmd changes after capture are ignored; cmd_q is the only source for S/R.
- Owner dropping req mid-sequence: no abort, so the latch never sees a truncated pulse. The sequence completes and done still pulses.
- Owner still holding req in the IDLE after its own DONE: treated as a new request. Round-robin hands priority to the other requester if it is also requesting.
- Invariants:
  - latch_s and latch_r are never 1 simultaneously.
  - latch_c is never 1 outside PULSE.
  - S/R never change while latch_c=1.
- Counter width is clog2 of max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1. The counter resets to 0 on every state change.

Decomposition:
- Package sr_latch_ctrl_pkg holds:
  - state enum (IDLE, SETUP, PULSE, HOLD, DONE)
  - command enum (CMD_REFRESH=2'b00, CMD_SET=2'b01, CMD_RESET=2'b10, CMD_ILLEGAL=2'b11)
  - a function computing counter width
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], advance.
  - Output: one-hot grant.
  - The pointer updates only when advance=1, i.e. on the IDLE grant edge.

Test Plan:
- Set via requester 0: req=01, cmd0=01 -> gnt=01; latch_s=1 in cycles 1-6; latch_c=1 in cycles 3-5; latch_r=0 throughout; done=01 in cycle 7; err=0.
- Contention: both req from reset, cmd0=01, cmd1=10, both held.
  - Requester 0 served first (done=01 at cycle 7).
  - One IDLE cycle follows, then requester 1 granted with latch_r pulse.
  - done=10 at cycle 15.
  - Both req kept high afterwards -> grants alternate 0,1,0.
- Illegal command: cmd1=11, req=10 -> busy for exactly one cycle; done=10 and err=1 in cycle 1; latch_s/r/c stay 0.
- Refresh and stability: cmd0=00 -> latch_c pulses 3 cycles with S=R=0. During any sequence, toggling cmd0 and dropping req after grant produces no change on S/R and done still fires at cycle 7.
- Reset mid-PULSE: assert rst_n=0 while latch_c=1 -> S/R/C/gnt/busy drop to 0 immediately without a clock edge; no done. After release, requester 0 wins a simultaneous request.
- Parameter sweep SETUP_CYC=1, PULSE_CYC=1, HOLD_CYC=1 -> done at cycle 4. Assert the invariants (S&R never 1; C only in PULSE; S/R stable while C=1) on every cycle.
